// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-handle clients: default address/data
// widths and the state encoding of the region stream reader.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_SIZE = 23;  // memory word-address width
  localparam int DATA_SIZE = 32;  // memory word width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } rsr_state_e;

endpackage : mem_pkg

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Register-based FIFO whose head entry is driven straight from storage flops,
// so a word pushed in cycle N is visible at pop_data in cycle N+1.
// Push and pop in the same cycle are accepted at any occupancy, including full.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data (ignored when full unless popping too)
//   push_data  in   WIDTH-bit entry
//   pop        in   remove head entry (ignored when empty)
//   pop_data   out  head entry, meaningful only while valid
//   valid      out  FIFO not empty
//   count      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int DEPTH = 4,   // power of two, 2..16
  parameter int WIDTH = 33
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // When full, the slot being popped this cycle is the one written.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // which entries are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule : stream_fifo

// File: rtl/region_stream_reader.sv
// -----------------------------------------------------------------------------
// region_stream_reader
// Reads the inclusive word range [region_begin, region_end] through a
// single-outstanding memory handle and streams the words out through a
// valid/ready interface, flagging the word read from region_end with out_last.
//
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   start, region_begin, region_end   one-cycle request and its region
//   busy, finished                    operation status / completion pulse
//   mem_region_begin/end, mem_ptr     latched region and current read address
//   mem_r_en, mem_w_en                read request (held until done), write=0
//   mem_read_through, mem_write_through, mem_data_store   tied 0
//   mem_avail, mem_done, mem_data_load                    memory responses
//   out_valid, out_ready, out_data, out_last              output stream
// -----------------------------------------------------------------------------
module region_stream_reader
  import mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_SIZE,
  parameter int DATA_W     = DATA_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] region_begin,
  input  logic [ADDR_W-1:0] region_end,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] mem_region_begin,
  output logic [ADDR_W-1:0] mem_region_end,
  output logic [ADDR_W-1:0] mem_ptr,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              mem_read_through,
  output logic              mem_write_through,
  output logic [DATA_W-1:0] mem_data_store,
  input  logic              mem_avail,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  rsr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] begin_q, begin_d;
  logic [ADDR_W-1:0] end_q, end_d;

  logic              fifo_push, fifo_pop, fifo_valid;
  logic [DATA_W:0]   fifo_push_data, fifo_pop_data;
  logic [CNT_W-1:0]  fifo_count;

  assign fifo_pop       = fifo_valid && out_ready;
  assign fifo_push_data = {(ptr_q == end_q), mem_data_load};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    begin_d   = begin_q;
    end_d     = end_q;
    mem_r_en  = 1'b0;
    fifo_push = 1'b0;
    finished  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          begin_d = region_begin;
          end_d   = region_end;
          ptr_d   = region_begin;
          state_d = (region_begin > region_end) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        // Only one read is ever outstanding, so a free slot now is still
        // free when its data returns.
        mem_r_en = (fifo_count < CNT_W'(FIFO_DEPTH));
        if (mem_r_en && mem_avail) state_d = WAIT;
      end
      WAIT: begin
        mem_r_en = 1'b1;
        if (mem_done) begin
          fifo_push = 1'b1;
          ptr_d     = ptr_q + ADDR_W'(1);
          // Termination keys off the last flag, so a region ending at the
          // top address never relies on the pointer wrapping.
          state_d   = (ptr_q == end_q) ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        // Complete in the cycle the final buffered word is accepted.
        if (!fifo_valid || ((fifo_count == CNT_W'(1)) && fifo_pop)) begin
          finished = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      begin_q <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      begin_q <= begin_d;
      end_q   <= end_d;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // busy drops in the same cycle finished pulses.
  assign busy              = (state_q != IDLE) && !finished;
  assign mem_region_begin  = begin_q;
  assign mem_region_end    = end_q;
  assign mem_ptr           = ptr_q;
  assign mem_w_en          = 1'b0;
  assign mem_read_through  = 1'b0;
  assign mem_write_through = 1'b0;
  assign mem_data_store    = '0;
  // Storage is unreset, so the head is masked until an entry is valid.
  assign out_valid         = fifo_valid;
  assign out_data          = fifo_valid ? fifo_pop_data[DATA_W-1:0] : '0;
  assign out_last          = fifo_valid && fifo_pop_data[DATA_W];

endmodule : region_stream_reader

// File: tb/tb_region_stream_reader.sv
module tb_region_stream_reader;
  import mem_pkg::*;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] region_begin, region_end;
  logic          busy, finished;
  logic [AW-1:0] mem_region_begin, mem_region_end, mem_ptr;
  logic          mem_r_en, mem_w_en, mem_read_through, mem_write_through;
  logic [DW-1:0] mem_data_store;
  logic          mem_avail, mem_done;
  logic [DW-1:0] mem_data_load;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;

  always #5 clock = ~clock;

  region_stream_reader #(.FIFO_DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .region_begin      (region_begin),
    .region_end        (region_end),
    .busy              (busy),
    .finished          (finished),
    .mem_region_begin  (mem_region_begin),
    .mem_region_end    (mem_region_end),
    .mem_ptr           (mem_ptr),
    .mem_r_en          (mem_r_en),
    .mem_w_en          (mem_w_en),
    .mem_read_through  (mem_read_through),
    .mem_write_through (mem_write_through),
    .mem_data_store    (mem_data_store),
    .mem_avail         (mem_avail),
    .mem_done          (mem_done),
    .mem_data_load     (mem_data_load),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {9'h15A, a};
  endfunction

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: accepts a request when mem_r_en && mem_avail, answers
  // with a one-cycle mem_done 'lat' cycles after the request cycle.
  int            lat         = 2;
  bit            avail_block = 1'b0;
  bit            pending     = 1'b0;
  int            cnt         = 0;
  logic [AW-1:0] req_addr;
  int            req_count   = 0;

  initial begin
    mem_avail     = 1'b1;
    mem_done      = 1'b0;
    mem_data_load = '0;
    forever begin
      @(negedge clock);
      mem_done  = 1'b0;
      mem_avail = !avail_block;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          mem_done      = 1'b1;
          mem_data_load = word_of(req_addr);
          pending       = 1'b0;
        end
      end else if (mem_r_en && mem_avail) begin
        pending  = 1'b1;
        cnt      = lat;
        req_addr = mem_ptr;
        req_count++;
      end
    end
  end

  // Stream monitor.
  logic [DW:0]   word_q [$];
  int            fin_count = 0;
  int            fin_cyc   = 0;
  bit            busy_at_fin, busy_before_fin, prev_busy;
  bit            r_en_seen, valid_seen;
  bit            prev_hold = 1'b0;
  bit            prev_rst  = 1'b1;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  initial begin
    forever begin
      @(negedge clock);
      if (prev_hold && !prev_rst && !reset) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_word", 64'({out_last, out_data}), 64'({prev_last, prev_data}));
      end
      if (out_valid && out_ready) word_q.push_back({out_last, out_data});
      if (finished) begin
        fin_count++;
        fin_cyc         = cyc;
        busy_at_fin     = busy;
        busy_before_fin = prev_busy;
      end
      r_en_seen  |= mem_r_en;
      valid_seen |= out_valid;
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_busy  = busy;
      prev_rst   = reset;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] e);
    region_begin = b;
    region_end   = e;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int base);
    int n = 0;
    while (fin_count == base && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, 64'(fin_count - base), 64'(1));
  endtask

  task automatic check_words(input string tag, input logic [AW-1:0] b, input int n);
    check({tag, "_count"}, 64'(word_q.size()), 64'(n));
    for (int i = 0; i < n && i < word_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), 64'(word_q[i]),
            64'({(i == n - 1), word_of(AW'(b + AW'(i)))}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int fb, rb, start_cyc, n;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    region_begin = '0;
    region_end   = '0;
    out_ready    = 1'b1;
    tick(3);

    check("rst_busy",      64'(busy),             64'(0));
    check("rst_finished",  64'(finished),         64'(0));
    check("rst_r_en",      64'(mem_r_en),         64'(0));
    check("rst_out_valid", 64'(out_valid),        64'(0));
    check("rst_out_last",  64'(out_last),         64'(0));
    check("rst_ptr",       64'(mem_ptr),          64'(0));
    check("rst_begin",     64'(mem_region_begin), 64'(0));
    check("rst_end",       64'(mem_region_end),   64'(0));
    check("rst_w_en",      64'(mem_w_en),         64'(0));

    // Reset overrides a coincident start.
    region_begin = 23'h11;
    region_end   = 23'h55;
    start        = 1'b1;
    tick(1);
    start = 1'b0;
    check("rst_over_start_busy", 64'(busy),           64'(0));
    check("rst_over_start_end",  64'(mem_region_end), 64'(0));
    reset = 1'b0;
    tick(2);

    // Basic four-word region.
    word_q.delete();
    fb = fin_count;
    do_start(23'h10, 23'h13);
    wait_fin("t1_fin", fb);
    tick(3);
    check("t1_fin_once",    64'(fin_count - fb),  64'(1));
    check_words("t1", 23'h10, 4);
    check("t1_busy_at_fin", 64'(busy_at_fin),     64'(0));
    check("t1_busy_before", 64'(busy_before_fin), 64'(1));
    check("t1_busy_after",  64'(busy),            64'(0));

    // Back-pressure: buffer fills after four reads.
    word_q.delete();
    out_ready = 1'b0;
    rb = req_count;
    fb = fin_count;
    do_start(23'h20, 23'h27);
    tick(40);
    check("t2_reqs_stalled", 64'(req_count - rb), 64'(4));
    check("t2_r_en_low",     64'(mem_r_en),       64'(0));
    check("t2_head",         64'({out_valid, out_last, out_data}),
                             64'({1'b1, 1'b0, word_of(23'h20)}));
    check("t2_no_words",     64'(word_q.size()),  64'(0));
    out_ready = 1'b1;
    wait_fin("t2_fin", fb);
    tick(2);
    check("t2_reqs_total", 64'(req_count - rb), 64'(8));
    check_words("t2", 23'h20, 8);

    // Empty region.
    word_q.delete();
    rb = req_count;
    fb = fin_count;
    r_en_seen  = 1'b0;
    valid_seen = 1'b0;
    start_cyc  = cyc;
    do_start(23'h5, 23'h4);
    wait_fin("t3_fin", fb);
    check("t3_latency",    64'(fin_cyc - start_cyc), 64'(1));
    check("t3_no_r_en",    64'(r_en_seen),           64'(0));
    check("t3_no_valid",   64'(valid_seen),          64'(0));
    check("t3_no_request", 64'(req_count - rb),      64'(0));

    // Memory not available for ten cycles while issuing.
    word_q.delete();
    avail_block = 1'b1;
    rb = req_count;
    fb = fin_count;
    do_start(23'h30, 23'h31);
    tick(1);
    check("t4_ptr_issue", 64'(mem_ptr), 64'(23'h30));
    tick(10);
    check("t4_r_en_held", 64'(mem_r_en),       64'(1));
    check("t4_ptr_held",  64'(mem_ptr),        64'(23'h30));
    check("t4_no_accept", 64'(req_count - rb), 64'(0));
    avail_block = 1'b0;
    wait_fin("t4_fin", fb);
    check("t4_reqs", 64'(req_count - rb), 64'(2));
    check_words("t4", 23'h30, 2);

    // Reset during WAIT with buffered words, then a late mem_done.
    word_q.delete();
    out_ready = 1'b0;
    lat = 4;
    rb = req_count;
    fb = fin_count;
    do_start(23'h40, 23'h43);
    n = 0;
    while (!(pending && (req_count - rb == 3)) && n < 200) begin
      tick(1);
      n++;
    end
    check("t5_reach_wait", 64'(req_count - rb), 64'(3));
    reset = 1'b1;
    tick(1);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick(10);
    check("t5_busy",      64'(busy),             64'(0));
    check("t5_finished",  64'(finished),         64'(0));
    check("t5_r_en",      64'(mem_r_en),         64'(0));
    check("t5_out_valid", 64'(out_valid),        64'(0));
    check("t5_out_last",  64'(out_last),         64'(0));
    check("t5_ptr",       64'(mem_ptr),          64'(0));
    check("t5_begin",     64'(mem_region_begin), 64'(0));
    check("t5_end",       64'(mem_region_end),   64'(0));
    check("t5_no_words",  64'(word_q.size()),    64'(0));
    check("t5_no_fin",    64'(fin_count - fb),   64'(0));
    lat = 2;
    word_q.delete();
    fb = fin_count;
    do_start(23'h50, 23'h51);
    wait_fin("t5_new_fin", fb);
    check_words("t5_new", 23'h50, 2);

    // Single word at the top of the address space.
    word_q.delete();
    rb = req_count;
    fb = fin_count;
    do_start(23'h7FFFFF, 23'h7FFFFF);
    wait_fin("t6_fin", fb);
    tick(10);
    check_words("t6", 23'h7FFFFF, 1);
    check("t6_one_request", 64'(req_count - rb), 64'(1));
    check("t6_r_en_low",    64'(mem_r_en),       64'(0));
    check("t6_fin_once",    64'(fin_count - fb), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_region_stream_reader

// File: doc/region_stream_reader.md
REGION_STREAM_READER -- requirements
Module: region_stream_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving output buffer depth in words; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default `ADDR_SIZE (23), giving memory word-address width.
REQ-003 SHALL have parameter DATA_W, default `DATA_SIZE (32), giving memory word width.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; latches region_begin/region_end.
REQ-007 region_begin  in  ADDR_W  first word address, inclusive.
REQ-008 region_end  in  ADDR_W  last word address, inclusive.
REQ-009 busy  out  1  high from the cycle after accepted start until finished.
REQ-010 finished  out  1  one-cycle pulse when the last word is accepted downstream.
REQ-011 mem_region_begin, mem_region_end  out  ADDR_W  latched region, driven to the memory handle.
REQ-012 mem_ptr  out  ADDR_W  current read address.
REQ-013 mem_r_en  out  1  read request.
REQ-014 mem_w_en  out  1  tied 0.
REQ-015 mem_read_through  out  1  tied 0; mem_write_through tied 0; mem_data_store tied 0.
REQ-016 mem_avail  in  1  memory can accept a request.
REQ-017 mem_done  in  1  one-cycle pulse; mem_data_load valid in that cycle.
REQ-018 mem_data_load  in  DATA_W  read data.
REQ-019 out_valid  out  1  stream word valid; out_ready in 1 consumer accepts.
REQ-020 out_data  out  DATA_W  stream word; out_last out 1 marks the word read from region_end.

Function
REQ-021 SHALL use FSM states IDLE, ISSUE, WAIT, DRAIN.
REQ-022 IDLE: on start, latch the region and set ptr=region_begin; go to ISSUE, or to DRAIN when region_begin>region_end (zero words).
REQ-023 ISSUE: raise mem_r_en only when FIFO occupancy<FIFO_DEPTH; a request is accepted when mem_r_en&&mem_avail; accepted -> WAIT.
REQ-024 WAIT: hold mem_r_en=1 and mem_ptr stable until mem_done; on mem_done, push mem_data_load with last=(ptr==region_end); then ptr+1 and go to ISSUE, or to DRAIN if last.
REQ-025 At most one read SHALL be outstanding; occupancy check counts the in-flight word, so the FIFO never overflows.
REQ-026 DRAIN: wait until FIFO empty and the last word has been accepted; pulse finished; go to IDLE. Zero-word region: finished one cycle after start, no memory request, no out_valid.
REQ-027 start while busy SHALL be ignored.
REQ-028 Stream: word transfers when out_valid&&out_ready; out_data/out_last held stable while out_valid&&!out_ready.
REQ-029 FIFO push and pop in the same cycle SHALL be legal at any occupancy, including full; occupancy is unchanged.
REQ-030 Latency: mem_done to out_valid SHALL be 1 cycle when the FIFO is empty (registered FIFO output).
REQ-031 ptr increment SHALL be ADDR_W wide; region_end = 2^ADDR_W-1 terminates on the last flag, not on wrap.
REQ-032 mem_done outside WAIT SHALL be ignored.

Reset
REQ-033 reset SHALL force IDLE, busy=0, finished=0, mem_r_en=0, out_valid=0, out_last=0, FIFO empty, mem_ptr/region registers 0; it overrides start and mem_done in the same cycle.
REQ-034 reset mid-operation SHALL discard buffered data; a late mem_done after reset is ignored.

Structure
REQ-035 ADDR_SIZE, DATA_SIZE and the FSM state enum SHALL live in shared package mem_pkg.
REQ-036 The buffer SHALL be sub-module stream_fifo (parameters DEPTH, WIDTH=DATA_W+1), carrying data plus the last flag.

Verification
REQ-037 begin=0x10, end=0x13, avail=1, done 2 cycles after request, ready=1 -> words from 0x10..0x13 in order, out_last only on word 4, finished once, busy falls the same cycle.
REQ-038 begin=0x20, end=0x27, ready=0 -> exactly 4 reads issued, then mem_r_en low; ready=1 -> remaining 4 reads, 8 words in order.
REQ-039 begin=5, end=4 -> finished 1 cycle after start, mem_r_en never high, out_valid never high.
REQ-040 avail held 0 for 10 cycles in ISSUE -> mem_r_en and mem_ptr stable; request accepted on the first cycle avail=1.
REQ-041 reset asserted during WAIT, then mem_done pulsed -> all outputs at reset values, no word emitted; a new start reads correctly.
REQ-042 begin=end=0x7FFFFF -> exactly one word with out_last=1, finished, no second request.
